// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster counters, sync generation and latency-aligned colour output
module vga_timing_controller #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int RGB_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] hLast      = 11'(H_TOTAL - 1);
    localparam logic [10:0] vLast      = 11'(V_TOTAL - 1);
    localparam logic [10:0] hVis       = 11'(H_VISIBLE);
    localparam logic [10:0] vVis       = 11'(V_VISIBLE);
    localparam logic [10:0] hSyncStart = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] hSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] vSyncStart = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] vSyncEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] sofLine    = 11'(V_VISIBLE - 1);
    logic       lineEnd;
    logic       frameEnd;
    logic [2:0] rawTiming;
    logic [2:0] dlyTiming;
    assign lineEnd  = pixelX == hLast;
    assign frameEnd = pixelY == vLast;
    // timing bundle is {visible, hsync, vsync}; syncs are active low
    assign rawTiming = {pixelX < hVis && pixelY < vVis,
                        !(pixelX >= hSyncStart && pixelX < hSyncEnd),
                        !(pixelY >= vSyncStart && pixelY < vSyncEnd)};
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            pixelX       <= lineEnd ? 11'd0 : pixelX + 11'd1;
            pixelY       <= lineEnd ? (frameEnd ? 11'd0 : pixelY + 11'd1) : pixelY;
            startOfFrame <= lineEnd && pixelY == sofLine;
        end
    end
    generate
        if (RGB_LATENCY == 0) begin : gNoDelay
            assign dlyTiming = rawTiming;
        end else begin : gDelay
            logic [2:0] pipe [RGB_LATENCY];
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < RGB_LATENCY; i++) pipe[i] <= 3'b011;
                end else begin
                    pipe[0] <= rawTiming;
                    for (int i = 1; i < RGB_LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign dlyTiming = pipe[RGB_LATENCY-1];
        end
    endgenerate
    // colour is sampled on the same edge as the aligned syncs so the DAC sees one coherent pixel
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blank <= 1'b1;
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            blank <= !dlyTiming[2];
            hsync <= dlyTiming[1];
            vsync <= dlyTiming[0];
            red   <= dlyTiming[2] ? {RGB_in[7:5], RGB_in[7]} : 4'd0;
            green <= dlyTiming[2] ? {RGB_in[4:2], RGB_in[4]} : 4'd0;
            blue  <= dlyTiming[2] ? {RGB_in[1:0], RGB_in[1:0]} : 4'd0;
        end
    end
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: directed vector table plus line/frame/reset sequences.
// Vertical timing is shortened (15 lines) to keep the run short; horizontal timing is the default.
module tb_vga_timing_controller;
    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = 800, VT = 15;

    logic        clk = 1'b0;
    logic        resetN;
    logic [7:0]  RGB_in;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hsync, vsync, blank;
    logic [3:0]  red, green, blue;

    int nChecks = 0;
    int nFail = 0;

    vga_timing_controller #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .RGB_LATENCY(1)
    ) dut (
        .clk(clk), .resetN(resetN), .RGB_in(RGB_in),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitPos(input int x, input int y, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (pixelX == 11'(x) && pixelY == 11'(y)) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        bit found;
        int n, w, y0, sofCnt, vsLow, maxY, wraps, prevY;
        // inputs sampled for pixel (x,y) appear on outputs two clocks after the counters show (x,y)
        vecs[0]  = '{10,  0,  8'hAE, 1'b1, 1'b1, 1'b0, 4'hB, 4'h6, 4'hA};
        vecs[1]  = '{639, 0,  8'hFF, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF};
        vecs[2]  = '{655, 0,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{2,   1,  8'h51, 1'b1, 1'b1, 1'b0, 4'h4, 4'h9, 4'h5};
        vecs[4]  = '{640, 1,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{656, 1,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{752, 1,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{751, 2,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{799, 2,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{100, 7,  8'hE3, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 4'hF};
        vecs[10] = '{639, 7,  8'hFF, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF};
        vecs[11] = '{100, 8,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{799, 9,  8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{3,   10, 8'hFF, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[14] = '{700, 11, 8'hFF, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[15] = '{3,   12, 8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[16] = '{799, 14, 8'hFF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};

        resetN = 1'b0;
        RGB_in = 8'hFF;
        repeat (10) @(negedge clk);
        check("rst_pixelX", int'(pixelX), 0);
        check("rst_pixelY", int'(pixelY), 0);
        check("rst_sof", int'(startOfFrame), 0);
        check("rst_syncs_blank", int'({hsync, vsync, blank}), 7);
        check("rst_colour", int'({red, green, blue}), 0);
        resetN = 1'b1;
        @(negedge clk);
        check("release_pixelX", int'(pixelX), 1);
        check("release_pixelY", int'(pixelY), 0);

        for (int i = 0; i < 17; i++) begin
            RGB_in = vecs[i].rgb;
            waitPos(vecs[i].x, vecs[i].y, HT * VT + 10, found);
            check($sformatf("vec%0d_reached", i), int'(found), 1);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_hsync", i), int'(hsync), int'(vecs[i].hs));
            check($sformatf("vec%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
            check($sformatf("vec%0d_blank", i), int'(blank), int'(vecs[i].bl));
            check($sformatf("vec%0d_red", i), int'(red), int'(vecs[i].r));
            check($sformatf("vec%0d_green", i), int'(green), int'(vecs[i].g));
            check($sformatf("vec%0d_blue", i), int'(blue), int'(vecs[i].b));
        end

        n = 0;
        while (pixelX != 11'd656 && n < 2 * HT) begin
            @(negedge clk);
            n++;
        end
        check("line_find_656", int'(pixelX), 656);
        n = 0;
        while (hsync && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hsync_delay", n, 2);
        w = 0;
        while (!hsync && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("hsync_low_width", w, HS);
        n = 0;
        while (pixelX != 11'd799 && n < 2 * HT) begin
            @(negedge clk);
            n++;
        end
        y0 = int'(pixelY);
        @(negedge clk);
        check("line_wrap_x", int'(pixelX), 0);
        check("line_wrap_y", int'(pixelY), (y0 == VT - 1) ? 0 : y0 + 1);

        n = 0;
        while (!startOfFrame && n < HT * VT + 10) begin
            @(negedge clk);
            n++;
        end
        check("sof_found", int'(startOfFrame), 1);
        check("sof_x", int'(pixelX), 0);
        check("sof_y", int'(pixelY), VV);
        sofCnt = 0;
        vsLow = 0;
        maxY = 0;
        wraps = 0;
        prevY = int'(pixelY);
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            sofCnt += int'(startOfFrame);
            vsLow += int'(!vsync);
            if (int'(pixelY) > maxY) maxY = int'(pixelY);
            if (int'(pixelY) < prevY) begin
                wraps++;
                check("frame_wrap_to_0", int'(pixelY), 0);
            end
            prevY = int'(pixelY);
        end
        check("sof_period_hit", int'(startOfFrame), 1);
        check("sof_per_frame", sofCnt, 1);
        check("vsync_low_clocks", vsLow, VS * HT);
        check("frame_max_y", maxY, VT - 1);
        check("frame_wraps", wraps, 1);

        RGB_in = 8'hFF;
        waitPos(300, 5, HT * VT + 10, found);
        check("midrst_reached", int'(found), 1);
        check("midrst_pre_red", int'(red), 15);
        #2 resetN = 1'b0;
        #1;
        check("midrst_pixelX", int'(pixelX), 0);
        check("midrst_pixelY", int'(pixelY), 0);
        check("midrst_syncs_blank", int'({hsync, vsync, blank}), 7);
        check("midrst_colour", int'({red, green, blue}), 0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            n++;
            if (startOfFrame) break;
        end
        check("midrst_sof_delay", n, VV * HT);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
